// File: rtl/cluster_frame_packer_if.sv
// Serial cluster stream from the cluster finder: BX strobe plus two ordered cluster lanes.
// The master drives the stream and cluster_frame_packer receives it on the slave side.
interface cluster_frame_packer_if;
    logic        bx_strobe;
    logic [1:0]  clust_vld;
    logic [13:0] clust_lane0;
    logic [13:0] clust_lane1;

    modport master (output bx_strobe, output clust_vld, output clust_lane0, output clust_lane1);
    modport slave  (input  bx_strobe, input  clust_vld, input  clust_lane0, input  clust_lane1);
endinterface

// File: rtl/cluster_frame_packer.sv
// Packs up to eight GEM clusters per bunch crossing into a registered frame for the trigger link.
// Clusters beyond slot 7 are dropped; each BX with a drop is flagged, and drops are counted with saturation.
module cluster_frame_packer #(
    parameter logic [13:0] EMPTY_CLUSTER = 14'h3FFF,
    parameter int          DROP_CNT_W    = 16
) (
    input  logic                  usrclk,
    input  logic                  reset,
    cluster_frame_packer_if.slave cin,
    output logic [13:0]           cluster0,
    output logic [13:0]           cluster1,
    output logic [13:0]           cluster2,
    output logic [13:0]           cluster3,
    output logic [13:0]           cluster4,
    output logic [13:0]           cluster5,
    output logic [13:0]           cluster6,
    output logic [13:0]           cluster7,
    output logic                  overflow,
    output logic [3:0]            frame_cnt,
    output logic                  frame_vld,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    localparam int NSLOTS = 8;

    logic [13:0]           acc_r      [NSLOTS];
    logic [13:0]           acc_next_s [NSLOTS];
    logic [13:0]           frame_r    [NSLOTS];
    logic [3:0]            wptr_r;
    logic                  ovf_acc_r;
    logic [3:0]            frame_cnt_r;
    logic                  overflow_r;
    logic                  frame_vld_r;
    logic [DROP_CNT_W-1:0] drop_cnt_r;

    logic [3:0]            base_s;
    logic [3:0]            tgt0_s;
    logic [3:0]            tgt1_s;
    logic                  wr0_s;
    logic                  wr1_s;
    logic [1:0]            drop_s;
    logic [3:0]            wptr_next_s;
    logic [DROP_CNT_W:0]   drop_sum_s;
    logic [DROP_CNT_W-1:0] drop_next_s;

    // Slot targeting for both lanes; a strobe cycle starts the new BX at slot 0 on a cleared accumulator.
    always_comb begin
        base_s = 4'd0;
        if (cin.bx_strobe) begin
            base_s = 4'd0;
        end else begin
            base_s = wptr_r;
        end
        tgt0_s      = base_s;
        tgt1_s      = base_s + {3'b000, cin.clust_vld[0]};
        wr0_s       = cin.clust_vld[0] && (tgt0_s < 4'd8);
        wr1_s       = cin.clust_vld[1] && (tgt1_s < 4'd8);
        drop_s      = {1'b0, cin.clust_vld[0] & ~wr0_s} + {1'b0, cin.clust_vld[1] & ~wr1_s};
        wptr_next_s = base_s + {3'b000, wr0_s} + {3'b000, wr1_s};
        for (int i = 0; i < NSLOTS; i++) begin
            if (wr0_s && (tgt0_s == 4'(i))) begin
                acc_next_s[i] = cin.clust_lane0;
            end else if (wr1_s && (tgt1_s == 4'(i))) begin
                acc_next_s[i] = cin.clust_lane1;
            end else if (cin.bx_strobe) begin
                acc_next_s[i] = EMPTY_CLUSTER;
            end else begin
                acc_next_s[i] = acc_r[i];
            end
        end
    end

    // Saturating add of this cycle's dropped clusters (0..2).
    always_comb begin
        drop_sum_s = {1'b0, drop_cnt_r} + {{(DROP_CNT_W-1){1'b0}}, drop_s};
        if (drop_sum_s[DROP_CNT_W]) begin
            drop_next_s = {DROP_CNT_W{1'b1}};
        end else begin
            drop_next_s = drop_sum_s[DROP_CNT_W-1:0];
        end
    end

    // Accumulator, frame output registers and drop counter.
    always_ff @(posedge usrclk) begin
        if (reset) begin
            for (int i = 0; i < NSLOTS; i++) begin
                acc_r[i]   <= EMPTY_CLUSTER;
                frame_r[i] <= EMPTY_CLUSTER;
            end
            wptr_r      <= 4'd0;
            ovf_acc_r   <= 1'b0;
            frame_cnt_r <= 4'd0;
            overflow_r  <= 1'b0;
            frame_vld_r <= 1'b0;
            drop_cnt_r  <= {DROP_CNT_W{1'b0}};
        end else begin
            acc_r       <= acc_next_s;
            wptr_r      <= wptr_next_s;
            frame_vld_r <= cin.bx_strobe;
            drop_cnt_r  <= drop_next_s;
            if (cin.bx_strobe) begin
                frame_r     <= acc_r;
                frame_cnt_r <= wptr_r;
                overflow_r  <= ovf_acc_r;
                ovf_acc_r   <= 1'b0;
            end else begin
                frame_r     <= frame_r;
                frame_cnt_r <= frame_cnt_r;
                overflow_r  <= overflow_r;
                ovf_acc_r   <= ovf_acc_r | (drop_s != 2'd0);
            end
        end
    end

    assign cluster0  = frame_r[0];
    assign cluster1  = frame_r[1];
    assign cluster2  = frame_r[2];
    assign cluster3  = frame_r[3];
    assign cluster4  = frame_r[4];
    assign cluster5  = frame_r[5];
    assign cluster6  = frame_r[6];
    assign cluster7  = frame_r[7];
    assign overflow  = overflow_r;
    assign frame_cnt = frame_cnt_r;
    assign frame_vld = frame_vld_r;
    assign drop_cnt  = drop_cnt_r;

endmodule

// File: tb/tb_cluster_frame_packer.sv
// Directed bench for cluster_frame_packer: one task per scenario, expected frames written out by hand.
module tb_cluster_frame_packer;

    localparam logic [13:0] EMPTY = 14'h3FFF;

    logic        usrclk;
    logic        reset;
    logic [13:0] cl [8];
    logic        overflow;
    logic [3:0]  frame_cnt;
    logic        frame_vld;
    logic [15:0] drop_cnt;
    int          tests_run;
    int          tests_failed;
    logic [13:0] exp_cl [8];

    cluster_frame_packer_if cin ();

    cluster_frame_packer dut (
        .usrclk    (usrclk),
        .reset     (reset),
        .cin       (cin),
        .cluster0  (cl[0]),
        .cluster1  (cl[1]),
        .cluster2  (cl[2]),
        .cluster3  (cl[3]),
        .cluster4  (cl[4]),
        .cluster5  (cl[5]),
        .cluster6  (cl[6]),
        .cluster7  (cl[7]),
        .overflow  (overflow),
        .frame_cnt (frame_cnt),
        .frame_vld (frame_vld),
        .drop_cnt  (drop_cnt)
    );

    initial usrclk = 1'b0;
    always #5 usrclk = ~usrclk;

    // Apply one cycle of input, clock it in, and settle 1 time unit past the edge.
    task automatic step(input logic strb, input logic [1:0] vld, input logic [13:0] l0, input logic [13:0] l1);
        cin.bx_strobe   = strb;
        cin.clust_vld   = vld;
        cin.clust_lane0 = l0;
        cin.clust_lane1 = l1;
        @(posedge usrclk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 2'b00, 14'h0000, 14'h0000);
    endtask

    task automatic set_exp_empty();
        for (int k = 0; k < 8; k++) exp_cl[k] = EMPTY;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(1'b0, 2'b00, 14'h0000, 14'h0000);
        step(1'b0, 2'b00, 14'h0000, 14'h0000);
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tests_run++;
            if (cl[k] !== EMPTY) begin
                tests_failed++;
                $display("FAIL reset_cluster%0d got %h expected %h", k, cl[k], EMPTY);
            end
        end
        tests_run++;
        if ({overflow, frame_cnt, frame_vld, drop_cnt} !== {1'b0, 4'd0, 1'b0, 16'd0}) begin
            tests_failed++;
            $display("FAIL reset_status got ovf=%b cnt=%0d vld=%b drop=%h expected 0/0/0/0000",
                     overflow, frame_cnt, frame_vld, drop_cnt);
        end
    endtask

    task automatic test_empty_frames();
        for (int b = 0; b < 2; b++) begin
            step(1'b1, 2'b00, 14'h0000, 14'h0000);
            for (int k = 0; k < 8; k++) begin
                tests_run++;
                if (cl[k] !== EMPTY) begin
                    tests_failed++;
                    $display("FAIL empty_cluster%0d got %h expected %h", k, cl[k], EMPTY);
                end
            end
            tests_run++;
            if ({frame_vld, overflow, frame_cnt} !== {1'b1, 1'b0, 4'd0}) begin
                tests_failed++;
                $display("FAIL empty_status got vld=%b ovf=%b cnt=%0d expected 1/0/0", frame_vld, overflow, frame_cnt);
            end
            idle(3);
            tests_run++;
            if (frame_vld !== 1'b0) begin
                tests_failed++;
                $display("FAIL empty_vld_drop got %b expected 0", frame_vld);
            end
        end
    endtask

    task automatic test_partial_frame();
        step(1'b1, 2'b00, 14'h0000, 14'h0000);
        step(1'b0, 2'b01, 14'h0011, 14'h0000);
        step(1'b0, 2'b11, 14'h0022, 14'h0033);
        step(1'b0, 2'b00, 14'h0000, 14'h0000);
        step(1'b1, 2'b00, 14'h0000, 14'h0000);
        set_exp_empty();
        exp_cl[0] = 14'h0011;
        exp_cl[1] = 14'h0022;
        exp_cl[2] = 14'h0033;
        for (int k = 0; k < 8; k++) begin
            tests_run++;
            if (cl[k] !== exp_cl[k]) begin
                tests_failed++;
                $display("FAIL partial_cluster%0d got %h expected %h", k, cl[k], exp_cl[k]);
            end
        end
        tests_run++;
        if ({frame_vld, overflow, frame_cnt} !== {1'b1, 1'b0, 4'd3}) begin
            tests_failed++;
            $display("FAIL partial_status got vld=%b ovf=%b cnt=%0d expected 1/0/3", frame_vld, overflow, frame_cnt);
        end
        idle(3);
    endtask

    task automatic test_full_frame();
        step(1'b1, 2'b11, 14'h0A01, 14'h0A02);
        step(1'b0, 2'b11, 14'h0A03, 14'h0A04);
        step(1'b0, 2'b11, 14'h0A05, 14'h0A06);
        step(1'b0, 2'b11, 14'h0A07, 14'h0A08);
        step(1'b1, 2'b00, 14'h0000, 14'h0000);
        exp_cl[0] = 14'h0A01; exp_cl[1] = 14'h0A02; exp_cl[2] = 14'h0A03; exp_cl[3] = 14'h0A04;
        exp_cl[4] = 14'h0A05; exp_cl[5] = 14'h0A06; exp_cl[6] = 14'h0A07; exp_cl[7] = 14'h0A08;
        for (int k = 0; k < 8; k++) begin
            tests_run++;
            if (cl[k] !== exp_cl[k]) begin
                tests_failed++;
                $display("FAIL full_cluster%0d got %h expected %h", k, cl[k], exp_cl[k]);
            end
        end
        tests_run++;
        if ({overflow, frame_cnt, drop_cnt} !== {1'b0, 4'd8, 16'd0}) begin
            tests_failed++;
            $display("FAIL full_status got ovf=%b cnt=%0d drop=%h expected 0/8/0000", overflow, frame_cnt, drop_cnt);
        end
        idle(3);
    endtask

    task automatic test_overflow();
        step(1'b1, 2'b01, 14'h0B01, 14'h0000);
        step(1'b0, 2'b11, 14'h0B02, 14'h0B03);
        step(1'b0, 2'b11, 14'h0B04, 14'h0B05);
        step(1'b0, 2'b11, 14'h0B06, 14'h0B07);
        step(1'b0, 2'b11, 14'h0B08, 14'h0B09);
        step(1'b1, 2'b00, 14'h0000, 14'h0000);
        for (int k = 0; k < 8; k++) begin
            exp_cl[k] = 14'h0B01 + 14'(k);
            tests_run++;
            if (cl[k] !== exp_cl[k]) begin
                tests_failed++;
                $display("FAIL ovf_cluster%0d got %h expected %h", k, cl[k], exp_cl[k]);
            end
        end
        tests_run++;
        if ({overflow, frame_cnt, drop_cnt} !== {1'b1, 4'd8, 16'd1}) begin
            tests_failed++;
            $display("FAIL ovf_status got ovf=%b cnt=%0d drop=%h expected 1/8/0001", overflow, frame_cnt, drop_cnt);
        end
        idle(3);
        step(1'b1, 2'b00, 14'h0000, 14'h0000);
        tests_run++;
        if ({overflow, frame_cnt, drop_cnt, frame_vld} !== {1'b0, 4'd0, 16'd1, 1'b1}) begin
            tests_failed++;
            $display("FAIL ovf_next_bx got ovf=%b cnt=%0d drop=%h vld=%b expected 0/0/0001/1",
                     overflow, frame_cnt, drop_cnt, frame_vld);
        end
        idle(3);
    endtask

    task automatic test_strobe_cycle_cluster();
        step(1'b1, 2'b10, 14'h0000, 14'h0101);
        tests_run++;
        if ({cl[0], frame_cnt} !== {EMPTY, 4'd0}) begin
            tests_failed++;
            $display("FAIL strobe_current got cl0=%h cnt=%0d expected %h/0", cl[0], frame_cnt, EMPTY);
        end
        idle(3);
        step(1'b1, 2'b00, 14'h0000, 14'h0000);
        set_exp_empty();
        exp_cl[0] = 14'h0101;
        for (int k = 0; k < 8; k++) begin
            tests_run++;
            if (cl[k] !== exp_cl[k]) begin
                tests_failed++;
                $display("FAIL strobe_next_cluster%0d got %h expected %h", k, cl[k], exp_cl[k]);
            end
        end
        tests_run++;
        if (frame_cnt !== 4'd1) begin
            tests_failed++;
            $display("FAIL strobe_next_cnt got %0d expected 1", frame_cnt);
        end
        idle(3);
    endtask

    task automatic test_reset_mid_bx_and_saturation();
        step(1'b1, 2'b01, 14'h0C01, 14'h0000);
        step(1'b0, 2'b01, 14'h0C02, 14'h0000);
        step(1'b0, 2'b01, 14'h0C03, 14'h0000);
        reset = 1'b1;
        step(1'b0, 2'b00, 14'h0000, 14'h0000);
        reset = 1'b0;
        tests_run++;
        if ({drop_cnt, frame_cnt, cl[0]} !== {16'd0, 4'd0, EMPTY}) begin
            tests_failed++;
            $display("FAIL midreset_regs got drop=%h cnt=%0d cl0=%h expected 0000/0/%h", drop_cnt, frame_cnt, cl[0], EMPTY);
        end
        step(1'b1, 2'b00, 14'h0000, 14'h0000);
        for (int k = 0; k < 8; k++) begin
            tests_run++;
            if (cl[k] !== EMPTY) begin
                tests_failed++;
                $display("FAIL midreset_cluster%0d got %h expected %h", k, cl[k], EMPTY);
            end
        end
        tests_run++;
        if ({frame_cnt, overflow, frame_vld} !== {4'd0, 1'b0, 1'b1}) begin
            tests_failed++;
            $display("FAIL midreset_status got cnt=%0d ovf=%b vld=%b expected 0/0/1", frame_cnt, overflow, frame_vld);
        end
        // After 4 filling cycles every further cycle drops both lanes.
        for (int n = 0; n < 10; n++) step(1'b0, 2'b11, 14'h3FFF, 14'h3FFF);
        tests_run++;
        if (drop_cnt !== 16'd12) begin
            tests_failed++;
            $display("FAIL drop_count12 got %0d expected 12", drop_cnt);
        end
        for (int n = 10; n < 32771; n++) step(1'b0, 2'b11, 14'h0D01, 14'h0D02);
        tests_run++;
        if (drop_cnt !== 16'hFFFE) begin
            tests_failed++;
            $display("FAIL drop_near_sat got %h expected fffe", drop_cnt);
        end
        step(1'b0, 2'b11, 14'h0D01, 14'h0D02);
        tests_run++;
        if (drop_cnt !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL drop_sat got %h expected ffff", drop_cnt);
        end
        for (int n = 0; n < 5; n++) step(1'b0, 2'b11, 14'h0D01, 14'h0D02);
        step(1'b1, 2'b00, 14'h0000, 14'h0000);
        tests_run++;
        if ({drop_cnt, overflow, frame_cnt, cl[0], cl[7]} !== {16'hFFFF, 1'b1, 4'd8, EMPTY, EMPTY}) begin
            tests_failed++;
            $display("FAIL drop_hold got drop=%h ovf=%b cnt=%0d cl0=%h cl7=%h expected ffff/1/8/%h/%h",
                     drop_cnt, overflow, frame_cnt, cl[0], cl[7], EMPTY, EMPTY);
        end
        idle(3);
    endtask

    initial begin
        tests_run       = 0;
        tests_failed    = 0;
        reset           = 1'b1;
        cin.bx_strobe   = 1'b0;
        cin.clust_vld   = 2'b00;
        cin.clust_lane0 = 14'h0000;
        cin.clust_lane1 = 14'h0000;
        test_reset();
        test_empty_frames();
        test_partial_frame();
        test_full_frame();
        test_overflow();
        test_strobe_cycle_cluster();
        test_reset_mid_bx_and_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
